elevator_controller: RTL
========================

# elevator_controller

Parametrised N-floor elevator controller with a latched call-request register, per-floor travel timing, timed door dwell and SCAN (sweep-direction) scheduling. It replaces the single-target up/down state machine in the top level. `current_floor` drives the existing 7-segment floor decoder, and the status outputs drive spare `uo_out`/`uio_out` pins.

## Interface
- `NUM_FLOORS`, default 8: number of floors, 2..16.
- `FLOOR_W`, default `$clog2(NUM_FLOORS)`: floor index width.
- `TRAVEL_TICKS`, default 10000000: clock cycles to move one floor, ≥1.
- `DOOR_TICKS`, default 20000000: clock cycles the door stays open, ≥1.
- `clk`, in, 1: the only clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: call request strobe, sampled every cycle.
- `req_floor`, in, `FLOOR_W`: requested floor; values ≥ `NUM_FLOORS` are ignored.
- `current_floor`, out, `FLOOR_W`: last floor reached.
- `pending`, out, `NUM_FLOORS`: one bit per outstanding request.
- `dir_up`, out, 1: sweep direction (1 = up).
- `moving`, out, 1: high in the MOVE_UP and MOVE_DOWN states.
- `door_open`, out, 1: high in the DOOR state.
- `idle`, out, 1: high in the IDLE state.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. All outputs are registered.
- Reset values: state IDLE, `current_floor`=0, `pending`=0, `dir_up`=1, both timers 0, `moving`=0, `door_open`=0, `idle`=1.
- Request latch: a valid, in-range `req_valid` sets `pending[req_floor]` at that edge. Exception: if the state is DOOR and `req_floor`==`current_floor`, the bit is not set and the door timer restarts instead.
- Derived terms: `above` = any pending bit above `current_floor`; `below` = any pending bit below it. Both are computed from the registered `pending`.
- IDLE:
  - `pending[current_floor]` set → DOOR, and that bit is cleared.
  - Else `dir_up` and `above` → MOVE_UP.
  - Else `below` → MOVE_DOWN with `dir_up`=0.
  - Else `above` → MOVE_UP with `dir_up`=1.
  - Else stay in IDLE.
- MOVE_x:
  - The travel timer counts 0..`TRAVEL_TICKS`-1.
  - On the terminal count, `current_floor` steps ±1 and the timer clears.
  - If `pending` of the new floor is set → DOOR, and that bit is cleared.
  - Otherwise stay in MOVE_x.
  - A MOVE state is entered only when a request lies ahead. Pending bits clear only when serviced, so the floor index never passes floor 0 or `NUM_FLOORS`-1.
- DOOR:
  - The door timer counts 0..`DOOR_TICKS`-1.
  - On the terminal count, apply the sweep rule:
    - Requests ahead in `dir_up` → move in that direction.
    - Else requests behind → reverse `dir_up` and move.
    - Else → IDLE.
- Requests raised while moving for floors already passed are kept and served on the return sweep.

## Timing
- A request at edge N is visible in `pending` after N. From IDLE, the earliest state change is at edge N+1.
- `current_floor` changes exactly `TRAVEL_TICKS` cycles after entering MOVE_x, and every `TRAVEL_TICKS` cycles after that.
- DOOR lasts exactly `DOOR_TICKS` cycles unless the timer is restarted by a same-floor request.
- Arrival step and state change to DOOR happen on the same edge. The serviced `pending` bit clears on that same edge.
- A same-cycle new request and service clear for different floors both take effect.
- `reset` asserted mid-travel or mid-dwell returns all state to its reset values on the next edge. Outstanding requests are discarded.

## Configuration
- Macro: `ELEVATOR_ESTOP_EN`.
- Defined:
  - Adds input `estop` (1 bit, level) and output `halted` (1 bit, registered).
  - While `estop`=1: both timers and the state freeze, `halted`=1, and `moving`/`door_open` hold their values.
  - Requests are still latched during the freeze.
  - Resume is from the frozen timer value one cycle after `estop` falls.
  - `reset` overrides `estop`.
- Undefined: neither port exists, and the behaviour is identical to `estop`=0.

## Structure
- Package `elevator_pkg`: state enum `elev_state_t` (IDLE, MOVE_UP, MOVE_DOWN, DOOR) and the direction constants `DIR_UP`/`DIR_DOWN`.
- Sub-module `tick_timer`:
  - Parameter `TICKS`; ports `clk`, `reset`, `clr`, `en`, `done`.
  - `done` pulses on count `TICKS`-1.
  - Instantiated twice: travel timer and door timer.
- Above/below mask generation stays in the top as combinational code.

## Test plan
Bench parameters: `NUM_FLOORS`=8, `TRAVEL_TICKS`=4, `DOOR_TICKS`=3.
- Reset, then idle 20 cycles → `current_floor`=0, `idle`=1, `pending`=0 throughout.
- Request floor 3 from floor 0 → `moving` from cycle 2. `current_floor` reaches 1, 2, 3 at 4-cycle spacing. `door_open` lasts 3 cycles, `pending`=0, then IDLE.
- At floor 3 with `dir_up`=1, request 1 and 5 on the same cycle → serve 5 first, then reverse: `current_floor` 5, then 1. `dir_up`=0 after the reversal.
- Request floor 4 while moving up between floors 1 and 2 → stops at 4 without passing it. Door dwell occurs at 4.
- Request the current floor during DOOR → dwell extends 3 cycles from that request. `pending` stays 0.
- `reset` mid-travel with `pending`=8'h90 → next cycle: all outputs at reset values, `pending`=0. With `ELEVATOR_ESTOP_EN`: `estop` for 10 cycles mid-travel → `current_floor` frozen, `halted`=1, arrival delayed by exactly 10 cycles.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared state encoding and direction constants for the elevator controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } elev_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_controller_tick_timer.sv
// Free-running modulo-TICKS counter; done pulses on the last count while enabled.
module tick_timer #(
  parameter int TICKS = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] count;

  assign done = en && !clr && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// N-floor SCAN elevator controller with latched calls, travel timing and door dwell.
// Optional emergency stop (estop input, halted output) under `ELEVATOR_ESTOP_EN.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = $clog2(NUM_FLOORS),
  parameter int TRAVEL_TICKS = 10000000,
  parameter int DOOR_TICKS   = 20000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
  output logic                  halted,
`endif
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  idle
);

  localparam logic [FLOOR_W:0] NF = (FLOOR_W + 1)'(NUM_FLOORS);

  elev_state_t           state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d, floor_up, floor_dn;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] le_mask, lt_mask;
  logic                  dir_q, dir_d;
  logic                  moving_q, door_q, idle_q;
  logic                  req_ok, door_restart;
  logic                  above, below;
  logic                  travel_done, door_done;
  logic                  freeze;

`ifdef ELEVATOR_ESTOP_EN
  logic halted_q;
  assign freeze = estop;
  assign halted = halted_q;
  always_ff @(posedge clk) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= estop;
  end
`else
  assign freeze = 1'b0;
`endif

  assign req_ok       = req_valid && ({1'b0, req_floor} < NF);
  assign door_restart = (state_q == DOOR) && req_ok && (req_floor == floor_q);
  assign floor_up     = floor_q + FLOOR_W'(1);
  assign floor_dn     = floor_q - FLOOR_W'(1);

  // lt_mask: floors strictly below current; le_mask: floors at or below current.
  always_comb begin
    lt_mask = (NUM_FLOORS'(1) << floor_q) - 1'b1;
    le_mask = (NUM_FLOORS'(2) << floor_q) - 1'b1;
    above   = |(pending_q & ~le_mask);
    below   = |(pending_q & lt_mask);
  end

  tick_timer #(.TICKS(TRAVEL_TICKS)) u_travel_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (!((state_q == MOVE_UP) || (state_q == MOVE_DOWN))),
    .en    (!freeze),
    .done  (travel_done)
  );

  tick_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != DOOR) || door_restart),
    .en    (!freeze),
    .done  (door_done)
  );

  // New requests are set before service clears so a same-edge clear wins.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    if (req_ok && !door_restart) pending_d[req_floor] = 1'b1;
    if (!freeze) begin
      unique case (state_q)
        IDLE: begin
          if (pending_q[floor_q]) begin
            state_d            = DOOR;
            pending_d[floor_q] = 1'b0;
          end else if (dir_q && above) begin
            state_d = MOVE_UP;
          end else if (below) begin
            state_d = MOVE_DOWN;
            dir_d   = DIR_DOWN;
          end else if (above) begin
            state_d = MOVE_UP;
            dir_d   = DIR_UP;
          end
        end
        MOVE_UP: begin
          if (travel_done) begin
            floor_d = floor_up;
            if (pending_q[floor_up]) begin
              state_d             = DOOR;
              pending_d[floor_up] = 1'b0;
            end
          end
        end
        MOVE_DOWN: begin
          if (travel_done) begin
            floor_d = floor_dn;
            if (pending_q[floor_dn]) begin
              state_d             = DOOR;
              pending_d[floor_dn] = 1'b0;
            end
          end
        end
        DOOR: begin
          if (door_done) begin
            if ((dir_q == DIR_UP) && above) begin
              state_d = MOVE_UP;
            end else if ((dir_q == DIR_DOWN) && below) begin
              state_d = MOVE_DOWN;
            end else if ((dir_q == DIR_UP) && below) begin
              state_d = MOVE_DOWN;
              dir_d   = DIR_DOWN;
            end else if ((dir_q == DIR_DOWN) && above) begin
              state_d = MOVE_UP;
              dir_d   = DIR_UP;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      pending_q <= '0;
      dir_q     <= DIR_UP;
      moving_q  <= 1'b0;
      door_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      moving_q  <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
      door_q    <= (state_d == DOOR);
      idle_q    <= (state_d == IDLE);
    end
  end

  assign current_floor = floor_q;
  assign pending       = pending_q;
  assign dir_up        = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_q;
  assign idle          = idle_q;

endmodule
